uart_tx_fifo: RTL and testbench

Transmit buffer that sits directly upstream of the UART transmitter. It accepts bytes from the CPU bus side in single-cycle writes and stores them in a circular FIFO. A drain FSM hands bytes one at a time to the transmitter over its en/busy handshake, so the CPU can queue a burst without polling the busy signal. It also provides level, full, empty and sticky-overflow status for the bus register block.

---
 rtl/uart_tx_fifo_pkg.sv | 19 +
 rtl/uart_tx_fifo_if.sv | 36 +++
 rtl/uart_fifo_ram.sv | 23 ++
 rtl/uart_tx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: drain FSM encoding,
// default geometry and the occupancy-width helper.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } drain_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side write/status signals plus the transmitter en/busy handshake of the
// UART transmit buffer, bundled so the buffer and its environment share one port.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int LVL_W = level_w(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              flush;
  logic              ovf_clr;
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  // Handshake: tx_en is a one-cycle strobe, issued only while tx_busy is low;
  // the transmitter raises tx_busy the cycle after it samples tx_en and drops
  // it when the frame ends. tx_data stays stable until the next strobe.
  logic              tx_en;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;

  modport slave (
    input  wr_en, wr_data, flush, ovf_clr, tx_busy,
    output full, empty, level, overflow, tx_en, tx_data
  );

  modport master (
    output wr_en, wr_data, flush, ovf_clr, tx_busy,
    input  full, empty, level, overflow, tx_en, tx_data
  );

endinterface

// File: rtl/uart_fifo_ram.sv
// Simple dual-port register array: synchronous write, combinational read.
module uart_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: circular FIFO filled from the bus side and drained one
// byte at a time into the transmitter over its en/busy handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  uart_tx_fifo_if.slave       bus,
  output drain_state_e        dbg_state
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = level_w(DEPTH);
  localparam int TMR_W  = $clog2(BUSY_TIMEOUT + 1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count, count_next;
  logic [TMR_W-1:0]  timer;
  drain_state_e      state, state_next;
  logic              pop;
  logic              wr_accept, wr_drop;
  logic [DATA_W-1:0] rd_data;
  logic              tx_en_q, overflow_q, full_q, empty_q;
  logic [DATA_W-1:0] tx_data_q;

  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
  always_comb begin
    wr_accept = bus.wr_en && !bus.flush && ((count < LVL_W'(DEPTH)) || pop);
    wr_drop   = bus.wr_en && !bus.flush && !wr_accept;
  end

  always_comb begin
    count_next = count;
    if (bus.flush)              count_next = '0;
    else if (wr_accept && !pop) count_next = count + LVL_W'(1);
    else if (pop && !wr_accept) count_next = count - LVL_W'(1);
  end

  // Drain FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= (state == WAIT_BUSY && state_next == WAIT_BUSY) ? timer + TMR_W'(1) : '0;
    end
  end

  // Drain FSM: next state. A byte whose busy never rises is abandoned.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)                              state_next = WAIT_DONE;
        else if (timer == TMR_W'(BUSY_TIMEOUT - 1))  state_next = IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Drain FSM: outputs. Flush suppresses a pop in its cycle.
  always_comb begin
    pop = (state == IDLE) && (count != '0) && !bus.tx_busy && !bus.flush;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      count   <= count_next;
      full_q  <= (count_next == LVL_W'(DEPTH));
      empty_q <= (count_next == '0);
      tx_en_q <= pop;
      if (pop) tx_data_q <= rd_data;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_accept) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)       rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (wr_drop)          overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.level    = count;
  assign bus.overflow = overflow_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = tx_data_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a transmitter model drives tx_busy and a
// negedge monitor checks every tx_en byte against the expected queue.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int FRAME = 6;
  localparam int BUSY_MODEL = 0;
  localparam int BUSY_HIGH  = 1;
  localparam int BUSY_LOW   = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  drain_state_e dbg_state;

  uart_tx_fifo_if #(.DATA_W(8), .DEPTH(DEPTH)) bus();

  uart_tx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int tx_count = 0;
  int busy_mode = BUSY_MODEL;
  int frame_cnt = 0;
  logic en_seen = 1'b0;
  logic prev_en = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // transmitter model: busy rises the cycle after tx_en, lasts FRAME cycles
  always @(posedge clk) begin
    #1;
    if (busy_mode == BUSY_MODEL) begin
      if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) bus.tx_busy = 1'b0;
      end
      if (en_seen) begin
        bus.tx_busy = 1'b1;
        frame_cnt = FRAME;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    en_seen = bus.tx_en;
    if (bus.tx_en) begin
      tx_count++;
      check("tx_en_spacing", {31'd0, prev_en}, 32'd0);
      check("busy_low_at_pop", {31'd0, bus.tx_busy}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%0h expected no byte", bus.tx_data);
      end else begin
        check("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_en = bus.tx_en;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit expect_out);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    if (expect_out) exp_q.push_back(d);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while (!(exp_q.size() == 0 && dbg_state == IDLE && bus.tx_busy == 1'b0 && bus.empty) && i < budget) begin
      step();
      i++;
    end
    check({name, "_drain_timeout"}, {31'd0, i < budget}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int max_lvl;
    int i;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.flush = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.tx_busy = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_level", {27'd0, bus.level}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("rst_tx_en", {31'd0, bus.tx_en}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    resetn = 1'b1;
    step();

    // single byte, fall-through latency
    base = tx_count;
    write_byte(8'hA5, 1'b1);
    check("t1_level_fill", {27'd0, bus.level}, 32'd1);
    step();
    check("t1_tx_en", {31'd0, bus.tx_en}, 32'd1);
    check("t1_tx_data", {24'd0, bus.tx_data}, 32'hA5);
    check("t1_level_after_pop", {27'd0, bus.level}, 32'd0);
    check("t1_empty", {31'd0, bus.empty}, 32'd1);
    wait_drain("t1", 100);
    check("t1_pulses", tx_count - base, 32'd1);

    // ordering with back-to-back writes
    base = tx_count;
    max_lvl = 0;
    for (int k = 1; k <= 5; k++) begin
      write_byte(8'(k), 1'b1);
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
    end
    check("t2_peak_level", {31'd0, max_lvl >= 4 && max_lvl <= 5}, 32'd1);
    wait_drain("t2", 300);
    check("t2_pulses", tx_count - base, 32'd5);

    // overflow with busy held high
    busy_mode = BUSY_HIGH;
    bus.tx_busy = 1'b1;
    step();
    for (int k = 0; k < DEPTH + 2; k++) write_byte(8'(8'h10 + k), k < DEPTH);
    check("t3_full", {31'd0, bus.full}, 32'd1);
    check("t3_level", {27'd0, bus.level}, 32'd16);
    check("t3_overflow", {31'd0, bus.overflow}, 32'd1);
    check("t3_not_empty", {31'd0, bus.empty}, 32'd0);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("t3_ovf_clr", {31'd0, bus.overflow}, 32'd0);

    // full FIFO: write in the same cycle as the pop
    base = tx_count;
    bus.tx_busy = 1'b0;
    frame_cnt = 0;
    busy_mode = BUSY_MODEL;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h99;
    exp_q.push_back(8'h99);
    step();
    bus.wr_en = 1'b0;
    check("t4_level", {27'd0, bus.level}, 32'd16);
    check("t4_full", {31'd0, bus.full}, 32'd1);
    check("t4_overflow", {31'd0, bus.overflow}, 32'd0);
    check("t4_tx_en", {31'd0, bus.tx_en}, 32'd1);
    wait_drain("t4", 600);
    check("t4_pulses", tx_count - base, 32'd17);

    // flush with one byte in flight
    base = tx_count;
    for (int k = 0; k < 7; k++) write_byte(8'(8'h40 + k), k == 0);
    check("t5_level_pre", {27'd0, bus.level}, 32'd6);
    bus.flush = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h77;
    step();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    check("t5_level", {27'd0, bus.level}, 32'd0);
    check("t5_empty", {31'd0, bus.empty}, 32'd1);
    check("t5_overflow", {31'd0, bus.overflow}, 32'd0);
    wait_drain("t5", 100);
    repeat (20) step();
    check("t5_pulses", tx_count - base, 32'd1);

    // busy timeout
    busy_mode = BUSY_LOW;
    bus.tx_busy = 1'b0;
    base = tx_count;
    write_byte(8'h3C, 1'b1);
    step();
    check("t6_tx_en", {31'd0, bus.tx_en}, 32'd1);
    check("t6_state_wait", {30'd0, dbg_state}, 32'd1);
    repeat (3) step();
    check("t6_state_before_timeout", {30'd0, dbg_state}, 32'd1);
    step();
    check("t6_state_idle", {30'd0, dbg_state}, 32'd0);
    check("t6_pulses", tx_count - base, 32'd1);

    // asynchronous reset during WAIT_DONE
    busy_mode = BUSY_MODEL;
    frame_cnt = 0;
    base = tx_count;
    write_byte(8'h5A, 1'b1);
    write_byte(8'h5B, 1'b0);
    i = 0;
    while (dbg_state != WAIT_DONE && i < 20) begin
      step();
      i++;
    end
    check("t7_reach_wait_done", {31'd0, i < 20}, 32'd1);
    check("t7_level_pre", {27'd0, bus.level}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("t7_tx_en", {31'd0, bus.tx_en}, 32'd0);
    check("t7_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("t7_level", {27'd0, bus.level}, 32'd0);
    check("t7_empty", {31'd0, bus.empty}, 32'd1);
    check("t7_full", {31'd0, bus.full}, 32'd0);
    check("t7_state", {30'd0, dbg_state}, 32'd0);
    frame_cnt = 0;
    bus.tx_busy = 1'b0;
    step();
    step();
    resetn = 1'b1;
    repeat (30) step();
    check("t7_pulses", tx_count - base, 32'd1);

    // final report
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
